// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: upstream stage of a 2:1 mux. Two single-entry valid/ready
// input buffers, a round-robin grant FSM driving d0/d1/sel, and a valid/ready
// handshake towards the consumer of the mux output. sel and the selected
// buffer are frozen while a grant is outstanding.
// Optional build macro MUX2_ARB_CNT_EN adds saturating per-channel transfer
// counters on ports cnt0/cnt1.
module mux2_rr_arbiter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic             sel,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MUX2_ARB_CNT_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    state_e           state_q;
    logic             full0_q, full1_q;
    logic [WIDTH-1:0] buf0_q, buf1_q;
    logic             sel_q;
    logic             last_q;      // channel granted by the most recent transfer
    logic             out_valid_q;

    logic xfer, xfer0, xfer1;

    assign xfer  = out_valid_q & out_ready;
    assign xfer0 = xfer & (state_q == GNT0);
    assign xfer1 = xfer & (state_q == GNT1);

    // ready is just !full, so there is no path from out_ready to the inputs
    assign in0_ready = ~full0_q;
    assign in1_ready = ~full1_q;
    assign d0        = buf0_q;
    assign d1        = buf1_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;

    // Input buffers: load only while empty, drain on a transfer of that channel
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            if (in0_valid && !full0_q) begin
                buf0_q  <= in0_data;
                full0_q <= 1'b1;
            end else if (xfer0) begin
                full0_q <= 1'b0;
            end
            if (in1_valid && !full1_q) begin
                buf1_q  <= in1_data;
                full1_q <= 1'b1;
            end else if (xfer1) begin
                full1_q <= 1'b0;
            end
        end
    end

    // Grant FSM with registered sel/out_valid; decisions use registered full flags
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (full0_q && (!full1_q || last_q)) begin
                        state_q     <= GNT0;
                        sel_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else if (full1_q) begin
                        state_q     <= GNT1;
                        sel_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                    end
                end
                GNT0: begin
                    if (xfer) begin
                        last_q <= 1'b0;
                        if (full1_q) begin
                            state_q <= GNT1;
                            sel_q   <= 1'b1;
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                GNT1: begin
                    if (xfer) begin
                        last_q <= 1'b1;
                        if (full0_q) begin
                            state_q <= GNT0;
                            sel_q   <= 1'b0;
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX2_ARB_CNT_EN
    logic [7:0] cnt0_q, cnt1_q;

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

    // Saturating per-channel transfer counters
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (xfer0 && cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'd1;
            if (xfer1 && cnt1_q != 8'hFF) cnt1_q <= cnt1_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: a table of per-cycle vectors covering reset,
// single-channel latency, simultaneous arrival, stalled grant, then streaming,
// mid-grant reset and (with MUX2_ARB_CNT_EN) counter saturation.
module tb_mux2_rr_arbiter;

    logic       clk, nReset;
    logic       in0_valid, in1_valid, out_ready;
    logic [1:0] in0_data, in1_data;
    logic       in0_ready, in1_ready, sel, out_valid;
    logic [1:0] d0, d1;
`ifdef MUX2_ARB_CNT_EN
    logic [7:0] cnt0, cnt1;
`endif

    int errors = 0;
    int checks = 0;

    mux2_rr_arbiter #(.WIDTH(2)) dut (
        .clk(clk), .nReset(nReset),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .d0(d0), .d1(d1), .sel(sel), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX2_ARB_CNT_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".out_valid"}, 32'(out_valid), 0);
        chk({nm, ".sel"}, 32'(sel), 0);
        chk({nm, ".d0"}, 32'(d0), 0);
        chk({nm, ".d1"}, 32'(d1), 0);
        chk({nm, ".in0_ready"}, 32'(in0_ready), 1);
        chk({nm, ".in1_ready"}, 32'(in1_ready), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nReset = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        in0_data = 2'd0;  in1_data = 2'd0;
        @(negedge clk);
        nReset = 1'b1;
    endtask

    typedef struct {
        bit       nrst;
        bit       v0;
        bit [1:0] di0;
        bit       v1;
        bit [1:0] di1;
        bit       ordy;
        bit       e_ov;
        bit       e_sel;
        bit [1:0] e_d0;
        bit [1:0] e_d1;
        bit       e_r0;
        bit       e_r1;
    } vec_t;

    vec_t tv[23];

    initial begin
        // nrst v0 di0 v1 di1 ordy | ov sel d0 d1 r0 r1
        tv[0]  = '{0, 1, 3, 1, 2, 1,  0, 0, 0, 0, 1, 1};  // held in reset, inputs toggling
        tv[1]  = '{0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 1, 1};
        tv[2]  = '{1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1};  // release: no change
        tv[3]  = '{1, 1, 2, 0, 0, 1,  0, 0, 0, 0, 1, 1};  // ch0 word 10 offered
        tv[4]  = '{1, 0, 0, 0, 0, 1,  0, 0, 2, 0, 0, 1};
        tv[5]  = '{1, 0, 0, 0, 0, 1,  1, 0, 2, 0, 0, 1};  // granted two cycles later
        tv[6]  = '{1, 0, 0, 0, 0, 1,  0, 0, 2, 0, 1, 1};  // ready again
        tv[7]  = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1};  // reset
        tv[8]  = '{1, 1, 1, 1, 3, 1,  0, 0, 0, 0, 1, 1};  // both channels together
        tv[9]  = '{1, 0, 0, 0, 0, 1,  0, 0, 1, 3, 0, 0};
        tv[10] = '{1, 0, 0, 0, 0, 1,  1, 0, 1, 3, 0, 0};  // ch0 wins the first tie
        tv[11] = '{1, 0, 0, 0, 0, 1,  1, 1, 1, 3, 1, 0};  // then ch1, no gap
        tv[12] = '{1, 0, 0, 0, 0, 1,  0, 1, 1, 3, 1, 1};  // idle, sel held
        tv[13] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1};  // reset
        tv[14] = '{1, 1, 2, 0, 0, 0,  0, 0, 0, 0, 1, 1};  // ch0, consumer stalled
        tv[15] = '{1, 0, 0, 1, 1, 0,  0, 0, 2, 0, 0, 1};  // ch1 arrives
        tv[16] = '{1, 0, 0, 0, 0, 0,  1, 0, 2, 1, 0, 0};
        tv[17] = '{1, 1, 3, 0, 0, 0,  1, 0, 2, 1, 0, 0};  // ch0 offer while full is ignored
        tv[18] = '{1, 0, 0, 1, 2, 0,  1, 0, 2, 1, 0, 0};  // ch1 offer while full is ignored
        tv[19] = '{1, 0, 0, 0, 0, 0,  1, 0, 2, 1, 0, 0};
        tv[20] = '{1, 0, 0, 0, 0, 1,  1, 0, 2, 1, 0, 0};  // consumer resumes
        tv[21] = '{1, 0, 0, 0, 0, 1,  1, 1, 2, 1, 1, 0};
        tv[22] = '{1, 0, 0, 0, 0, 1,  0, 1, 2, 1, 1, 1};
    end

    initial begin
        logic [1:0] q0[$], q1[$];
        logic [1:0] exp_w;
        logic       exp_sel, acc0, acc1, found;
        int         nxfer;

        nReset = 1'b1;
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        in0_data = 2'd0;  in1_data = 2'd0;
        #1 nReset = 1'b0;

        // Table-driven section: drive at negedge, outputs checked 1 time unit later
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            nReset    = tv[i].nrst;
            in0_valid = tv[i].v0;  in0_data = tv[i].di0;
            in1_valid = tv[i].v1;  in1_data = tv[i].di1;
            out_ready = tv[i].ordy;
            #1;
            chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(tv[i].e_ov));
            chk($sformatf("v%0d.sel", i),       32'(sel),       32'(tv[i].e_sel));
            chk($sformatf("v%0d.d0", i),        32'(d0),        32'(tv[i].e_d0));
            chk($sformatf("v%0d.d1", i),        32'(d1),        32'(tv[i].e_d1));
            chk($sformatf("v%0d.in0_ready", i), 32'(in0_ready), 32'(tv[i].e_r0));
            chk($sformatf("v%0d.in1_ready", i), 32'(in1_ready), 32'(tv[i].e_r1));
        end

        // Streaming: both channels always offering, consumer always ready.
        // Grants must alternate and carry each channel's words in order.
        do_reset();
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        in0_data = 2'd0;  in1_data = 2'd3;
        exp_sel = 1'b0;
        nxfer = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                chk($sformatf("stream%0d.sel", c), 32'(sel), 32'(exp_sel));
                if (exp_sel == 1'b0 && q0.size() > 0) begin
                    exp_w = q0.pop_front();
                    chk($sformatf("stream%0d.d0", c), 32'(d0), 32'(exp_w));
                end else if (exp_sel == 1'b1 && q1.size() > 0) begin
                    exp_w = q1.pop_front();
                    chk($sformatf("stream%0d.d1", c), 32'(d1), 32'(exp_w));
                end
                exp_sel = ~exp_sel;
                nxfer++;
            end
            acc0 = in0_ready;
            acc1 = in1_ready;
            if (acc0) q0.push_back(in0_data);
            if (acc1) q1.push_back(in1_data);
            @(posedge clk);
            #1;
            if (acc0) in0_data = in0_data + 2'd1;
            if (acc1) in1_data = in1_data - 2'd1;
        end
        checks++;
        if (nxfer < 15) begin
            errors++;
            $display("FAIL stream.rate: got %0d transfers expected at least 15", nxfer);
        end

        // Reset while a grant is outstanding: outputs return to reset values at once
        out_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) found = 1'b1;
        end
        chk("midreset.grant_seen", 32'(found), 1);
        nReset = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(negedge clk);
        nReset = 1'b1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        #1;
        chk_reset_vals("midreset_release");

`ifdef MUX2_ARB_CNT_EN
        // Saturation: 300 ch0 transfers
        do_reset();
        in0_valid = 1'b1; in0_data = 2'd1; out_ready = 1'b1;
        nxfer = 0;
        for (int c = 0; c < 2000 && nxfer < 300; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) nxfer++;
        end
        chk("cnt.xfers", 32'(nxfer), 300);
        in0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("cnt.cnt0", 32'(cnt0), 32'hFF);
        chk("cnt.cnt1", 32'(cnt1), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
